// File: rtl/modcount_chain.sv
// Cascaded modulo up/down counter chain (stage 0 least significant) with
// tick enable, parallel load, per-stage button adjust and registered compare.
module modcount_chain #(
  parameter int unsigned    N    = 3,
  parameter int unsigned    W    = 6,
  parameter logic [N*W-1:0] MODS = {6'd24, 6'd60, 6'd60}
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           ud,
  input  logic           clr,
  input  logic           ld,
  input  logic [N*W-1:0] ld_val,
  input  logic           adj_en,
  input  logic [2:0]     adj_sel,
  input  logic           adj_inc,
  input  logic           adj_dec,
  input  logic [N*W-1:0] cmp_val,
  input  logic           cmp_en,
  output logic [N*W-1:0] count,
  output logic           roll,
  output logic           match
);

  localparam int unsigned CW = N * W;
  localparam int unsigned WX = W + 1;

  logic          inc_q;
  logic          dec_q;
  logic          inc_rise;
  logic          dec_rise;
  logic [CW-1:0] count_nxt;
  logic          roll_nxt;
  logic          carry;
  logic [W-1:0]  cur;
  logic [W:0]    m;

  // Modulus of stage i widened to W+1 bits; a zero field encodes 2^W.
  function automatic logic [W:0] mod_of(input int unsigned i);
    logic [W-1:0] f;
    f = MODS[i*W +: W];
    return (f == '0) ? {1'b1, {W{1'b0}}} : {1'b0, f};
  endfunction

  // Increment with wrap, evaluated in W+1 bits before truncation.
  function automatic logic [W-1:0] step_up(input logic [W-1:0] v, input logic [W:0] md);
    logic [W:0] s;
    s = {1'b0, v} + WX'(1);
    return (s >= md) ? '0 : s[W-1:0];
  endfunction

  // Decrement with wrap from 0 to MOD-1.
  function automatic logic [W-1:0] step_dn(input logic [W-1:0] v, input logic [W:0] md);
    logic [W:0] s;
    s = (v == '0) ? (md - WX'(1)) : ({1'b0, v} - WX'(1));
    return s[W-1:0];
  endfunction

  assign inc_rise = adj_inc & ~inc_q;
  assign dec_rise = adj_dec & ~dec_q;

  // Next-state selection: clr > ld > adjust > tick, at most one applies.
  always_comb begin
    count_nxt = count;
    roll_nxt  = 1'b0;
    carry     = 1'b1;
    cur       = '0;
    m         = '0;
    if (clr) begin
      count_nxt = '0;
    end else if (ld) begin
      for (int unsigned i = 0; i < N; i++) begin
        m   = mod_of(i);
        cur = ld_val[i*W +: W];
        count_nxt[i*W +: W] = ({1'b0, cur} >= m) ? '0 : cur;
      end
    end else if (adj_en) begin
      if ((inc_rise ^ dec_rise) && (32'(adj_sel) < N)) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (32'(adj_sel) == i) begin
            m   = mod_of(i);
            cur = count[i*W +: W];
            count_nxt[i*W +: W] = inc_rise ? step_up(cur, m) : step_dn(cur, m);
          end
        end
      end
    end else if (tick) begin
      for (int unsigned i = 0; i < N; i++) begin
        m   = mod_of(i);
        cur = count[i*W +: W];
        if (carry) begin
          count_nxt[i*W +: W] = ud ? step_up(cur, m) : step_dn(cur, m);
        end
        carry = carry & (ud ? ({1'b0, cur} == (m - WX'(1))) : (cur == '0));
      end
      roll_nxt = carry;
    end
  end

  // State, output and button-history registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      roll  <= 1'b0;
      match <= 1'b0;
      inc_q <= 1'b0;
      dec_q <= 1'b0;
    end else begin
      count <= count_nxt;
      roll  <= roll_nxt;
      match <= cmp_en && (count == cmp_val);
      inc_q <= adj_inc;
      dec_q <= adj_dec;
    end
  end

endmodule

// File: tb/tb_modcount_chain.sv
// Scoreboard bench for modcount_chain: the driver pushes model predictions,
// a monitor pops and compares one entry per clock.
module tb_modcount_chain;

  localparam int unsigned N  = 3;
  localparam int unsigned W  = 6;
  localparam int unsigned CW = N * W;
  localparam logic [CW-1:0] MODS = {6'd24, 6'd60, 6'd60};

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          roll;
    logic          match;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          tick, ud, clr, ld, adj_en, adj_inc, adj_dec, cmp_en;
  logic [2:0]    adj_sel;
  logic [CW-1:0] ld_val, cmp_val, count;
  logic          roll, match;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk;
  int   n_fail;

  // reference model state: stage digits and button history
  int   mods[N];
  int   total;
  int   md[N];
  logic pinc, pdec;

  modcount_chain #(.N(N), .W(W), .MODS(MODS)) dut (
    .clk(clk), .rst(rst), .tick(tick), .ud(ud), .clr(clr), .ld(ld),
    .ld_val(ld_val), .adj_en(adj_en), .adj_sel(adj_sel), .adj_inc(adj_inc),
    .adj_dec(adj_dec), .cmp_val(cmp_val), .cmp_en(cmp_en),
    .count(count), .roll(roll), .match(match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [CW-1:0] act,
                                input logic [CW-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic logic [CW-1:0] hms(input int h, input int mi, input int s);
    return {6'(h), 6'(mi), 6'(s)};
  endfunction

  function automatic logic [CW-1:0] pack_md();
    logic [CW-1:0] p;
    p = '0;
    for (int i = 0; i < int'(N); i++) p[i*W +: W] = W'(md[i]);
    return p;
  endfunction

  // whole chain viewed as one mixed-radix number
  function automatic int to_val();
    int v;
    v = 0;
    for (int i = int'(N) - 1; i >= 0; i--) v = v * mods[i] + md[i];
    return v;
  endfunction

  task automatic from_val(input int val);
    int v;
    v = val;
    for (int i = 0; i < int'(N); i++) begin
      md[i] = v % mods[i];
      v     = v / mods[i];
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < int'(N); i++) md[i] = 0;
    pinc = 1'b0;
    pdec = 1'b0;
  endtask

  task automatic set_idle();
    tick = 1'b0; clr = 1'b0; ld = 1'b0; adj_en = 1'b0;
    adj_inc = 1'b0; adj_dec = 1'b0; adj_sel = 3'd0;
    cmp_en = 1'b0; cmp_val = '0; ld_val = '0; ud = 1'b1;
  endtask

  // Called at a negedge with inputs set: predict the next edge, then wait one cycle.
  task automatic step();
    exp_t e;
    logic ir, dr, r;
    int   v, f, s;
    e.match = cmp_en && (pack_md() == cmp_val);
    ir   = adj_inc && !pinc;
    dr   = adj_dec && !pdec;
    pinc = adj_inc;
    pdec = adj_dec;
    r    = 1'b0;
    if (clr) begin
      for (int i = 0; i < int'(N); i++) md[i] = 0;
    end else if (ld) begin
      for (int i = 0; i < int'(N); i++) begin
        f     = int'(ld_val[i*W +: W]);
        md[i] = (f >= mods[i]) ? 0 : f;
      end
    end else if (adj_en) begin
      s = int'(adj_sel);
      if ((ir != dr) && (s < int'(N)))
        md[s] = (md[s] + (ir ? 1 : mods[s] - 1)) % mods[s];
    end else if (tick) begin
      v = to_val();
      if (ud) begin
        r = (v == total - 1);
        v = (v + 1) % total;
      end else begin
        r = (v == 0);
        v = (v + total - 1) % total;
      end
      from_val(v);
    end
    e.cnt  = pack_md();
    e.roll = r;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: one prediction consumed per clock while out of reset.
  always @(posedge clk) begin
    #1;
    if (rst === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_empty: got no prediction expected one at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_count", count, mon_e.cnt);
        check("sb_roll", CW'(roll), CW'(mon_e.roll));
        check("sb_match", CW'(match), CW'(mon_e.match));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    total  = 1;
    for (int i = 0; i < int'(N); i++) begin
      mods[i] = (MODS[i*W +: W] == '0) ? (1 << W) : int'(MODS[i*W +: W]);
      total   = total * mods[i];
    end
    m_reset();
    set_idle();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_count", count, '0);
    check("rst_roll", CW'(roll), '0);
    check("rst_match", CW'(match), '0);
    rst = 1'b1;

    // 1: run to 00:00:05 with match armed, then async reset mid-cycle
    clr = 1'b1; step(); clr = 1'b0;
    cmp_val = hms(0, 0, 5); cmp_en = 1'b1; tick = 1'b1;
    repeat (5) step();
    tick = 1'b0; step();
    check("t1_count", count, hms(0, 0, 5));
    check("t1_match", CW'(match), CW'(1));
    rst = 1'b0;
    #1;
    check("t1_rst_count", count, '0);
    check("t1_rst_roll", CW'(roll), '0);
    check("t1_rst_match", CW'(match), '0);
    repeat (2) @(negedge clk);
    set_idle();
    m_reset();
    rst = 1'b1;

    // 2: up wrap of whole chain
    ld = 1'b1; ld_val = hms(23, 59, 58); step(); ld = 1'b0;
    tick = 1'b1; step();
    check("t2_count1", count, hms(23, 59, 59));
    check("t2_roll1", CW'(roll), '0);
    step();
    check("t2_count2", count, hms(0, 0, 0));
    check("t2_roll2", CW'(roll), CW'(1));
    tick = 1'b0; step();
    check("t2_roll3", CW'(roll), '0);

    // 3: down wrap
    ld = 1'b1; ld_val = hms(0, 0, 0); step(); ld = 1'b0;
    ud = 1'b0; tick = 1'b1; step();
    check("t3_count1", count, hms(23, 59, 59));
    check("t3_roll1", CW'(roll), CW'(1));
    step();
    check("t3_count2", count, hms(23, 59, 58));
    check("t3_roll2", CW'(roll), '0);
    tick = 1'b0; ud = 1'b1;

    // 4: adjust minutes, held button, both buttons, out-of-range select
    ld = 1'b1; ld_val = hms(10, 59, 30); step(); ld = 1'b0;
    adj_en = 1'b1; adj_sel = 3'd1; tick = 1'b1; adj_inc = 1'b1;
    repeat (5) step();
    check("t4_held", count, hms(10, 0, 30));
    adj_inc = 1'b0; step();
    adj_inc = 1'b1; adj_dec = 1'b1; step();
    check("t4_both", count, hms(10, 0, 30));
    adj_inc = 1'b0; adj_dec = 1'b0; step();
    adj_sel = 3'd5; adj_inc = 1'b1; step();
    check("t4_sel5", count, hms(10, 0, 30));
    adj_inc = 1'b0; adj_en = 1'b0; step();
    check("t4_resume", count, hms(10, 0, 31));
    tick = 1'b0;

    // 5: compare match timing, then disabled compare
    for (int rep = 0; rep < 2; rep++) begin
      cmp_val = hms(7, 30, 0); cmp_en = (rep == 0);
      ld = 1'b1; ld_val = hms(7, 29, 59); step(); ld = 1'b0;
      tick = 1'b1; step();
      check("t5_count", count, hms(7, 30, 0));
      check("t5_match0", CW'(match), '0);
      step();
      check("t5_match1", CW'(match), CW'(rep == 0));
      tick = 1'b0; step();
      check("t5_match2", CW'(match), '0);
    end
    cmp_en = 1'b0;

    // 6: out-of-range load, then clr beats ld and tick
    ld = 1'b1; ld_val = hms(25, 63, 10); step();
    check("t6_ldclip", count, hms(0, 0, 10));
    ld_val = hms(23, 59, 59); tick = 1'b1; clr = 1'b1; step();
    check("t6_clr", count, '0);
    check("t6_clr_roll", CW'(roll), '0);
    set_idle();

    // randomized phase
    for (int k = 0; k < 1500; k++) begin
      clr  = 1'($urandom_range(0, 63) == 0);
      ld   = 1'($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 2))
        0:       ld_val = CW'($urandom);
        1:       ld_val = hms(23, 59, int'($urandom_range(55, 59)));
        default: ld_val = hms(0, 0, int'($urandom_range(0, 3)));
      endcase
      if ($urandom_range(0, 31) == 0) adj_en = ~adj_en;
      tick = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) ud = 1'($urandom_range(0, 1));
      adj_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) adj_inc = ~adj_inc;
      if ($urandom_range(0, 3) == 0) adj_dec = ~adj_dec;
      if ($urandom_range(0, 15) == 0) cmp_en = ~cmp_en;
      if ($urandom_range(0, 7) == 0) cmp_val = pack_md();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
